// File: rtl/fbindct_pipe_if.sv
// Streaming port bundle for fbindct_pipe: vector in, coefficients out,
// each side with its own valid/ready pair plus tag and saturation sideband.
interface fbindct_pipe_if #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 20,
    parameter int TAG_WIDTH = 8
);
    logic signed [IN_WIDTH-1:0]  x_in [8];
    logic [TAG_WIDTH-1:0]        tag_in;
    logic                        valid_in;
    logic                        ready_in;
    logic signed [OUT_WIDTH-1:0] y_out [8];
    logic [TAG_WIDTH-1:0]        tag_out;
    logic                        sat_out;
    logic                        valid_out;
    logic                        ready_out;

    modport master (
        output x_in, tag_in, valid_in, ready_out,
        input  ready_in, y_out, tag_out, sat_out, valid_out
    );

    modport slave (
        input  x_in, tag_in, valid_in, ready_out,
        output ready_in, y_out, tag_out, sat_out, valid_out
    );
endinterface

// File: rtl/fbindct_pipe.sv
// Pipelined 8-point forward binDCT-C (shift-add lifting), one vector/clk.
// FBINDCT_ROUND_EN: round half up before the output shift instead of truncating.
module fbindct_pipe #(
    parameter int IN_WIDTH  = 20,
    parameter int INT_BITS  = 4,
    parameter int FRAC_BITS = 6,
    parameter int OUT_WIDTH = 20,
    parameter int OUT_FRAC  = 4,
    parameter int TAG_WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    fbindct_pipe_if.slave io
);
    localparam int W  = IN_WIDTH + INT_BITS + FRAC_BITS;
    localparam int SH = FRAC_BITS - OUT_FRAC;

    typedef logic signed [W-1:0] w_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    generate
        if (OUT_FRAC < 0 || OUT_FRAC > FRAC_BITS) begin : g_bad_q
            $error("fbindct_pipe: OUT_FRAC must lie in 0..FRAC_BITS");
        end
    endgenerate

    localparam w_t OMAX = w_t'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam w_t OMIN = ~OMAX;
`ifdef FBINDCT_ROUND_EN
    localparam w_t RND = w_t'((1 << SH) >> 1);
`else
    localparam w_t RND = '0;
`endif

    logic en;
    logic v0, v1, v2, v3;

    w_t   s0 [8];
    tag_t t0;
    w_t   a [8];
    tag_t t1;
    w_t   b0, b1, a4, a7;
    w_t   c [4];
    tag_t t2;
    w_t   c4, c5, c6, c7;
    w_t   d0, d1, d2, d3;
    tag_t t3;

    w_t b0_n, b1_n, d0_n, d2_n;
    w_t d4, d5, d6;
    w_t ov [8];
    w_t r;
    logic signed [OUT_WIDTH-1:0] y_n [8];
    logic clip;

    // One global enable: the whole pipe freezes when the output is blocked.
    assign en          = !io.valid_out || io.ready_out;
    assign io.ready_in = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (en) begin
            v0 <= io.valid_in;
            v1 <= v0;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_comb begin
        b0_n = a[6] + (a[5] >>> 2) + (a[5] >>> 3);
        b1_n = (b0_n >>> 1) + (b0_n >>> 3) - a[5];
        d0_n = c[0] + c[1];
        d2_n = c[2] - (c[3] >>> 2) - (c[3] >>> 3);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                s0[i] <= w_t'(io.x_in[i]) <<< FRAC_BITS;
            end
            t0 <= io.tag_in;

            for (int i = 0; i < 4; i++) begin
                a[i]   <= s0[i] + s0[7-i];
                a[7-i] <= s0[i] - s0[7-i];
            end
            t1 <= t0;

            b0   <= b0_n;
            b1   <= b1_n;
            a4   <= a[4];
            a7   <= a[7];
            c[0] <= a[0] + a[3];
            c[1] <= a[1] + a[2];
            c[2] <= a[1] - a[2];
            c[3] <= a[0] - a[3];
            t2   <= t1;

            c4 <= a4 + b1;
            c5 <= a4 - b1;
            c6 <= a7 - b0;
            c7 <= a7 + b0;
            d0 <= d0_n;
            d1 <= (d0_n >>> 1) - c[1];
            d2 <= d2_n;
            d3 <= c[3] + (d2_n >>> 2) + (d2_n >>> 3);
            t3 <= t2;
        end
    end

    always_comb begin
        d4 = c4 - (c7 >>> 3);
        d5 = c5 + (c6 >>> 1) + (c6 >>> 2) + (c6 >>> 3);
        d6 = c6 - (d5 >>> 1);
        ov[0] = d0;
        ov[1] = c7;
        ov[2] = d3;
        ov[3] = d6;
        ov[4] = d1;
        ov[5] = d5;
        ov[6] = d2;
        ov[7] = d4;
    end

    // Rescale to the output Q format, then clip to OUT_WIDTH.
    always_comb begin
        clip = 1'b0;
        r    = '0;
        for (int i = 0; i < 8; i++) begin
            r      = (ov[i] + RND) >>> SH;
            y_n[i] = r[OUT_WIDTH-1:0];
            if (r > OMAX) begin
                y_n[i] = OMAX[OUT_WIDTH-1:0];
                clip   = 1'b1;
            end else if (r < OMIN) begin
                y_n[i] = OMIN[OUT_WIDTH-1:0];
                clip   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.valid_out <= 1'b0;
            io.tag_out   <= '0;
            io.sat_out   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                io.y_out[i] <= '0;
            end
        end else if (en) begin
            io.valid_out <= v3;
            io.tag_out   <= t3;
            io.sat_out   <= clip;
            for (int i = 0; i < 8; i++) begin
                io.y_out[i] <= y_n[i];
            end
        end
    end
endmodule

// File: tb/tb_fbindct_pipe.sv
// Directed bench for fbindct_pipe: hand-computed vectors, latency,
// stall and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_fbindct_pipe;
    localparam int IW = 20;
    localparam int OW = 20;
    localparam int TW = 8;
`ifdef FBINDCT_ROUND_EN
    localparam int Y2C = 14;
`else
    localparam int Y2C = 13;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fbindct_pipe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TAG_WIDTH(TW)) io ();

    fbindct_pipe #(
        .IN_WIDTH (IW),
        .INT_BITS (4),
        .FRAC_BITS(6),
        .OUT_WIDTH(OW),
        .OUT_FRAC (4),
        .TAG_WIDTH(TW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    int total = 0;
    int bad   = 0;
    int vin [8][8];
    int ey  [8][8];
    int es  [8];
    int sidx [6];
    int qi [$];
    int qt [$];
    int cur_idx = 0;
    int cur_tag = 0;
    int tx = 0;
    int rx = 0;
    int rx0 = 0;
    int mk, mt;
    int stall_g;
    int rg;

    task automatic check(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic send(input int idx, input int tag);
        int guard = 0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) io.x_in[i] = IW'(vin[idx][i]);
        io.tag_in   = TW'(tag);
        io.valid_in = 1'b1;
        cur_idx     = idx;
        cur_tag     = tag;
        #1;
        while (!io.ready_in && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) check("send_timeout", 0, 1);
    endtask

    task automatic lat_check(input string nm);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) io.valid_in = 1'b0;
            #2;
            check($sformatf("%s_c%0d", nm, i), io.valid_out, (i == 5));
        end
    endtask

    task automatic drain();
        int g = 0;
        while (qi.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("drain", qi.size(), 0);
    endtask

    // Scoreboard: record accepted vectors, compare each delivered output.
    initial forever begin
        @(negedge clk);
        #1;
        if (io.valid_in && io.ready_in) begin
            qi.push_back(cur_idx);
            qt.push_back(cur_tag);
            tx++;
        end
        if (io.valid_out && io.ready_out) begin
            if (qi.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                mk = qi.pop_front();
                mt = qt.pop_front();
                rx++;
                check($sformatf("tag_n%0d", rx), io.tag_out, mt);
                check($sformatf("sat_v%0d", mk), io.sat_out, es[mk]);
                for (int i = 0; i < 8; i++)
                    check($sformatf("y%0d_v%0d", i, mk), io.y_out[i], ey[mk][i]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vin[0] = '{10, 10, 10, 10, 10, 10, 10, 10};
        ey[0]  = '{1280, 0, 0, 0, 0, 0, 0, 0};
        es[0]  = 0;
        vin[1] = '{16, 0, 0, 0, 0, 0, 0, 0};
        ey[1]  = '{256, 256, 220, 144, 128, 224, -96, -32};
        es[1]  = 0;
        vin[2] = '{1, 0, 0, 0, 0, 0, 0, 0};
        ey[2]  = '{16, 16, Y2C, 9, 8, 14, -6, -2};
        es[2]  = 0;
        vin[3] = '{524287, 524287, 524287, 524287,
                   524287, 524287, 524287, 524287};
        ey[3]  = '{524287, 0, 0, 0, 0, 0, 0, 0};
        es[3]  = 1;
        vin[4] = '{-524288, -524288, -524288, -524288,
                   -524288, -524288, -524288, -524288};
        ey[4]  = '{-524288, 0, 0, 0, 0, 0, 0, 0};
        es[4]  = 1;
        vin[5] = '{0, 0, 0, 16, 0, 0, 0, 0};
        ey[5]  = '{256, 0, -220, -128, 128, 256, 96, 256};
        es[5]  = 0;
        vin[6] = '{0, 0, 16, 0, 0, 0, 0, 0};
        ey[6]  = '{256, 96, -96, -152, -128, 112, -256, -208};
        es[6]  = 0;
        vin[7] = '{0, 0, 0, 0, 0, 0, 0, 16};
        ey[7]  = '{256, -256, 220, -144, 128, -224, -96, 32};
        es[7]  = 0;
        sidx   = '{1, 5, 6, 7, 0, 3};

        io.valid_in  = 1'b0;
        io.ready_out = 1'b1;
        io.tag_in    = '0;
        for (int i = 0; i < 8; i++) io.x_in[i] = '0;

        #12;
        check("rst_valid", io.valid_out, 0);
        check("rst_tag", io.tag_out, 0);
        check("rst_sat", io.sat_out, 0);
        check("rst_y0", io.y_out[0], 0);
        check("rst_ready", io.ready_in, 1);
        @(negedge clk);
        rst_n = 1'b1;

        send(0, 'h5A);
        lat_check("lat_a");
        for (int j = 1; j < 8; j++) send(j, 'h30 + j);
        @(negedge clk);
        io.valid_in = 1'b0;
        drain();

        rx0 = rx;
        fork
            begin
                for (int j = 0; j < 6; j++) send(sidx[j], 'h10 + j);
                @(negedge clk);
                io.valid_in = 1'b0;
            end
            begin
                stall_g = 0;
                do begin
                    @(negedge clk);
                    stall_g++;
                end while (!io.valid_out && stall_g < 40);
                io.ready_out = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #2;
                    check("stall_rdy", io.ready_in, 0);
                    check("stall_vld", io.valid_out, 1);
                    check("stall_tag", io.tag_out, 'h10);
                    check("stall_y0", io.y_out[0], ey[sidx[0]][0]);
                    check("stall_y2", io.y_out[2], ey[sidx[0]][2]);
                    @(negedge clk);
                end
                io.ready_out = 1'b1;
            end
        join
        drain();
        check("stream_count", rx - rx0, 6);

        for (int j = 0; j < 4; j++) send(j + 4, 'h40 + j);
        @(negedge clk);
        io.valid_in = 1'b0;
        rg = 0;
        while (!io.valid_out && rg < 20) begin
            @(negedge clk);
            rg++;
        end
        check("rst_pre_vld", io.valid_out, 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", io.valid_out, 0);
        check("arst_tag", io.tag_out, 0);
        check("arst_sat", io.sat_out, 0);
        check("arst_y0", io.y_out[0], 0);
        qi.delete();
        qt.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        rx0 = rx;
        send(2, 'h77);
        lat_check("lat_rst");
        drain();
        check("rst_count", rx - rx0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fbindct_pipe.md
Name: fbindct_pipe

Overview:
- Fully pipelined, parametrised 8-point forward binDCT-C (lifting/shift-add, no multipliers) for the JPEG-style transform path.
- Accepts one 8-sample vector per clock with valid/ready flow control on both sides.
- Carries a sideband tag and reports per-vector saturation.
- Output is rounded or truncated to a programmable Q format and saturated to OUT_WIDTH.
- Replaces the single-vector, 5-cycle-per-vector 1-D stage in row/column DCT engines.

Parameters:
- IN_WIDTH, 20: signed integer sample width.
- INT_BITS, 4: internal headroom bits.
- FRAC_BITS, 6: internal fractional bits; W = IN_WIDTH+INT_BITS+FRAC_BITS.
- OUT_WIDTH, 20: signed output coefficient width.
- OUT_FRAC, 4: fractional bits kept in the output. Constraint: 0 <= OUT_FRAC <= FRAC_BITS; elaboration error otherwise.
- TAG_WIDTH, 8: sideband tag width, passed through unchanged.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- x_in, in, 8 x IN_WIDTH signed: input vector x[0..7].
- tag_in, in, TAG_WIDTH: tag accompanying x_in.
- valid_in, in, 1: x_in/tag_in valid.
- ready_in, out, 1: block accepts a vector this cycle.
- y_out, out, 8 x OUT_WIDTH signed: coefficients y[0..7].
- tag_out, out, TAG_WIDTH: tag of the vector on y_out.
- sat_out, out, 1: at least one y of this vector was clipped.
- valid_out, out, 1: y_out/tag_out/sat_out valid.
- ready_out, in, 1: downstream accepts the output.

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits, y_out, tag_out, sat_out and valid_out to 0. Data registers are don't-care except outputs. A vector in flight when reset asserts is lost and never emitted.
- Handshake: transfer on valid&&ready. Global enable en = !valid_out || ready_out; ready_in = en (combinational).
- When en = 0, every stage holds, including data, valid and tag. valid_out and y_out stay stable until accepted.
- Bubbles are not compressed.
- Latency: a vector accepted at edge k appears with valid_out = 1 after edge k+4 when no stall occurs. Each stall cycle adds one. Throughput is 1 vector/clk when ready_out = 1.
- Internal format: each x[i] is sign-extended to W bits and left-shifted by FRAC_BITS. All >>> are arithmetic shifts on W-bit values. Adds wrap at W bits; INT_BITS guarantees no wrap for any legal input.
- S1 (register a):
  - a0=x0+x7, a1=x1+x6, a2=x2+x5, a3=x3+x4
  - a4=x3-x4, a5=x2-x5, a6=x1-x6, a7=x0-x7
- S2 (register b, c0..c3, pass a4, a7):
  - b0 = a6+(a5>>>2)+(a5>>>3); b1 = (b0>>>1)+(b0>>>3)-a5
  - c0=a0+a3, c1=a1+a2, c2=a1-a2, c3=a0-a3
- S3:
  - c4=a4+b1, c5=a4-b1, c6=a7-b0, c7=a7+b0
  - d0=c0+c1, d1=(d0>>>1)-c1
  - d2=c2-(c3>>>2)-(c3>>>3), d3=c3+(d2>>>2)+(d2>>>3)
- S4 (output register):
  - d4 = c7' with c7'=c4-(c7>>>3), i.e. d4=c4-(c7>>>3)
  - d5 = c5+(c6>>>1)+(c6>>>2)+(c6>>>3); d6 = c6-(d5>>>1)
  - Mapping: y0=d0, y1=c7, y2=d3, y3=d6, y4=d1, y5=d5, y6=d2, y7=d4.
- Output scaling in S4: r = v >>> (FRAC_BITS-OUT_FRAC) (see Optional Feature), then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- sat_out = OR over the 8 coefficients of "clipped".
- Tags travel in lockstep with data.
- Simultaneous output accept and new input: both occur in the same cycle with no bubble.

Optional Feature:
- Macro FBINDCT_ROUND_EN.
- Defined: before the output shift, add 2^(FRAC_BITS-OUT_FRAC-1) (round half up toward +inf). No addition when FRAC_BITS = OUT_FRAC.
- Undefined: plain arithmetic-shift truncation toward -inf.
- Saturation and all other behaviour are identical in both builds.

Test Plan:
- Default params, ready_out = 1, x = all 10, tag 0x5A accepted at edge 0 -> valid_out at edge 4, y = {1280,0,0,0,0,0,0,0}, tag_out 0x5A, sat_out 0.
- Impulse x0 = 16, others 0 -> y = {256,256,220,144,128,224,-96,-32}, sat_out 0 (both builds).
- Impulse x0 = 1 -> y2 = 13 without FBINDCT_ROUND_EN, 14 with it; y6 = -6 in both builds.
- x = all 524287 -> y0 = 524287, sat_out = 1, y1..y7 = 0.
- Stream 6 vectors back-to-back; hold ready_out low 3 cycles while vector 0 is on the output -> ready_in low during the stall, no vector lost or duplicated, order and tags preserved, stable y_out while stalled.
- Pulse rst_n low with 3 vectors in flight -> valid_out = 0 immediately (asynchronous); the next accepted vector emerges alone 4 cycles after acceptance.
